// File: rtl/log_capture_if.sv
// Register-file, datapath and RAM-port signals of log_capture_ctrl.
// i_trig exists only when LOG_TRIG_EN is defined.
interface log_capture_if #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 15,
  parameter int NB_DECIM = 8
);
  logic                i_run;
  logic                i_read;
  logic [NB_ADDR-1:0]  i_read_addr;
  logic [NB_DATA-1:0]  i_sample;
  logic                i_sample_vld;
  logic [NB_DECIM-1:0] i_decim;
`ifdef LOG_TRIG_EN
  logic                i_trig;
`endif
  logic                o_mem_we;
  logic [NB_ADDR-1:0]  o_mem_addr;
  logic [NB_DATA-1:0]  o_mem_wdata;
  logic [NB_DATA-1:0]  i_mem_rdata;
  logic [NB_DATA-1:0]  o_log_data;
  logic                o_log_vld;
  logic                o_mem_full;
  logic                o_busy;

  modport slave (
`ifdef LOG_TRIG_EN
    input  i_trig,
`endif
    input  i_run, i_read, i_read_addr, i_sample, i_sample_vld, i_decim, i_mem_rdata,
    output o_mem_we, o_mem_addr, o_mem_wdata, o_log_data, o_log_vld, o_mem_full, o_busy
  );

  modport master (
`ifdef LOG_TRIG_EN
    output i_trig,
`endif
    output i_run, i_read, i_read_addr, i_sample, i_sample_vld, i_decim, i_mem_rdata,
    input  o_mem_we, o_mem_addr, o_mem_wdata, o_log_data, o_log_vld, o_mem_full, o_busy
  );
endinterface

// File: rtl/log_capture_ctrl.sv
// Sample-log capture/readback sequencer owning a single-port sync RAM; write 1 cycle, read 2 cycles.
// No backpressure: samples and reads are pulses; LOG_TRIG_EN adds a trigger-armed start.
module log_capture_ctrl #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 15,
  parameter int NB_DECIM = 8
) (
  input  logic         clk,
  input  logic         i_rst,
  log_capture_if.slave bus
);

`ifdef LOG_TRIG_EN
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FULL, S_ARMED} state_t;
  localparam state_t S_START = S_ARMED;
`else
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FULL} state_t;
  localparam state_t S_START = S_CAPTURE;
`endif

  localparam logic [NB_ADDR:0]    PTR_ONE   = {{NB_ADDR{1'b0}}, 1'b1};
  localparam logic [NB_DECIM-1:0] DECIM_ONE = {{(NB_DECIM-1){1'b0}}, 1'b1};

  state_t              state_q;
  // Extra MSB marks "all DEPTH words written" without wrapping.
  logic [NB_ADDR:0]    wr_ptr_q;
  logic [NB_DECIM-1:0] decim_cnt_q;
  logic                mem_we_q;
  logic [NB_ADDR-1:0]  mem_addr_q;
  logic [NB_DATA-1:0]  mem_wdata_q;
  logic                rd_pend_q;
  logic                log_vld_q;
  logic [NB_DATA-1:0]  log_hold_q;
  logic                busy_q;
  logic                full_q;

  logic cnt_step;
  logic sample_take;
  logic rd_issue;

  always_comb begin
    cnt_step    = (state_q == S_CAPTURE) && !bus.i_run && !wr_ptr_q[NB_ADDR] && bus.i_sample_vld;
    sample_take = cnt_step && (decim_cnt_q == bus.i_decim);
`ifdef LOG_TRIG_EN
    if ((state_q == S_ARMED) && !bus.i_run && bus.i_trig && bus.i_sample_vld) begin
      sample_take = 1'b1;
    end
`endif
    rd_issue    = (state_q == S_FULL) && bus.i_read && !bus.i_run;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      decim_cnt_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      log_vld_q   <= 1'b0;
      log_hold_q  <= '0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      rd_pend_q <= rd_issue;
      log_vld_q <= rd_pend_q;
      if (log_vld_q) begin
        log_hold_q <= bus.i_mem_rdata;
      end
      if (sample_take) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= wr_ptr_q[NB_ADDR-1:0];
        mem_wdata_q <= bus.i_sample;
        wr_ptr_q    <= wr_ptr_q + PTR_ONE;
      end
      if (rd_issue) begin
        mem_addr_q <= bus.i_read_addr;
      end
      if (cnt_step) begin
        decim_cnt_q <= sample_take ? '0 : decim_cnt_q + DECIM_ONE;
      end

      // A run pulse restarts from any state; an in-flight write or read still drains.
      if (bus.i_run) begin
        state_q     <= S_START;
        wr_ptr_q    <= '0;
        decim_cnt_q <= '0;
        busy_q      <= 1'b1;
        full_q      <= 1'b0;
      end else begin
        case (state_q)
          S_CAPTURE: begin
            if (wr_ptr_q[NB_ADDR]) begin
              state_q <= S_FULL;
              busy_q  <= 1'b0;
              full_q  <= 1'b1;
            end
          end
`ifdef LOG_TRIG_EN
          S_ARMED: begin
            if (sample_take) begin
              state_q <= S_CAPTURE;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Sync RAM returns data in the strobe cycle; the hold register keeps it afterwards.
  assign bus.o_log_data  = log_vld_q ? bus.i_mem_rdata : log_hold_q;
  assign bus.o_log_vld   = log_vld_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_full  = full_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Bench for log_capture_ctrl with a 16-word RAM, directed scenarios and a randomized run against an event model.
module tb_log_capture_ctrl;
  localparam int NB_DATA  = 32;
  localparam int NB_ADDR  = 4;
  localparam int NB_DECIM = 8;
  localparam int DEPTH    = 16;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic i_rst;
  always #5 clk = ~clk;

  log_capture_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_DECIM(NB_DECIM)) bus ();

  log_capture_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_DECIM(NB_DECIM)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    bus.i_mem_rdata <= ram[bus.o_mem_addr];
  end

  // Reference model: phase 0 idle, 1 capturing, 2 full; acceptance by modulo of the valid-sample count.
  int          m_phase, m_v, m_n, p, g_decim;
  logic [31:0] mram [DEPTH];
  ev_t         exp_w[$], obs_w[$], exp_l[$], obs_l[$];
  int          n_cmp, n_fail, bf_bad, bf_first;

  task automatic drive(input bit rst, input bit run, input bit rd, input int ra,
                       input bit vld, input logic [31:0] s);
    bit eb, ef;
    i_rst            = rst;
    bus.i_run        = run;
    bus.i_read       = rd;
    bus.i_read_addr  = ra[3:0];
    bus.i_sample_vld = vld;
    bus.i_sample     = s;
    bus.i_decim      = g_decim[7:0];
    p++;
    if (rst) begin
      m_phase = 0;
      while (exp_l.size() > 0 && exp_l[$].cyc >= p) void'(exp_l.pop_back());
    end else if (run) begin
      m_phase = 1; m_v = 0; m_n = 0;
    end else if (m_phase == 1) begin
      if (m_n == DEPTH) m_phase = 2;
      else if (vld) begin
        if ((m_v + 1) % (g_decim + 1) == 0) begin
          exp_w.push_back('{cyc: p, addr: m_n, data: s});
          mram[m_n] = s;
          m_n++;
        end
        m_v++;
      end
    end else if (m_phase == 2 && rd) begin
      exp_l.push_back('{cyc: p + 1, addr: 0, data: mram[ra]});
    end
    eb = (m_phase == 1);
    ef = (m_phase == 2);
    @(posedge clk);
    #1;
    if (bus.o_mem_we) obs_w.push_back('{cyc: p, addr: int'(bus.o_mem_addr), data: bus.o_mem_wdata});
    if (bus.o_log_vld) obs_l.push_back('{cyc: p, addr: 0, data: bus.o_log_data});
    if ({bus.o_busy, bus.o_mem_full} !== {eb, ef}) begin
      if (bf_bad == 0) bf_first = p;
      bf_bad++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic clear_logs();
    exp_w.delete(); obs_w.delete(); exp_l.delete(); obs_l.delete();
    bf_bad = 0; bf_first = 0;
  endtask

  function automatic int first_diff(input ev_t a[$], input ev_t b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++)
      if (a[i].cyc != b[i].cyc || a[i].addr != b[i].addr || a[i].data !== b[i].data) return i;
    return (a.size() == b.size()) ? -1 : n;
  endfunction

  function automatic string ev_str(input ev_t q[$], input int i);
    if (i < 0 || i >= q.size()) return "none";
    return $sformatf("cyc=%0d addr=%0d data=%h", q[i].cyc, q[i].addr, q[i].data);
  endfunction

  task automatic test_reset();
    int d;
    clear_logs();
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h0);
    n_cmp++;
    if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_log_data, bus.o_log_vld,
         bus.o_mem_full, bus.o_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset.outputs: we=%b addr=%h wdata=%h ldata=%h lvld=%b full=%b busy=%b, required all 0",
               bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_log_data, bus.o_log_vld,
               bus.o_mem_full, bus.o_busy);
    end
    drive(0, 0, 1, 3, 0, 32'h0);
    idle(3);
    n_cmp++;
    if (obs_l.size() !== 0) begin
      n_fail++;
      $display("FAIL reset.idle_read: got %0d strobes, required 0", obs_l.size());
    end
    n_cmp++;
    if (bf_bad !== 0) begin
      n_fail++;
      $display("FAIL reset.busy_full: %0d bad cycles (first %0d), required 0", bf_bad, bf_first);
    end
  endtask

  task automatic test_capture_read();
    int d;
    clear_logs();
    g_decim = 0;
    drive(0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, 32'h100 + i);
    n_cmp++;
    if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_full} !== {1'b1, 4'hF, 32'h10F, 1'b0}) begin
      n_fail++;
      $display("FAIL capture.last_write: we=%b addr=%h data=%h full=%b, required 1 f 0000010f 0",
               bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_full);
    end
    idle(1);
    n_cmp++;
    if ({bus.o_busy, bus.o_mem_full} !== 2'b01) begin
      n_fail++;
      $display("FAIL capture.full_flag: busy/full=%b, required 01", {bus.o_busy, bus.o_mem_full});
    end
    drive(0, 0, 1, 5, 0, 32'h0);
    idle(1);
    n_cmp++;
    if ({bus.o_log_vld, bus.o_log_data} !== {1'b1, 32'h105}) begin
      n_fail++;
      $display("FAIL capture.read5: vld=%b data=%h, required 1 00000105", bus.o_log_vld, bus.o_log_data);
    end
    idle(1);
    n_cmp++;
    if ({bus.o_log_vld, bus.o_log_data} !== {1'b0, 32'h105}) begin
      n_fail++;
      $display("FAIL capture.hold: vld=%b data=%h, required 0 00000105", bus.o_log_vld, bus.o_log_data);
    end
    drive(0, 0, 1, 0, 0, 32'h0);
    drive(0, 0, 1, 15, 0, 32'h0);
    drive(0, 0, 1, 7, 0, 32'h0);
    idle(3);
    n_cmp++;
    if (obs_l.size() !== 4 || obs_l[1].data !== 32'h100 || obs_l[2].data !== 32'h10F ||
        obs_l[3].data !== 32'h107 || obs_l[3].cyc - obs_l[1].cyc !== 2) begin
      n_fail++;
      $display("FAIL capture.b2b: got %0d strobes, [1]=%s [2]=%s [3]=%s, required 100/10f/107 consecutive",
               obs_l.size(), ev_str(obs_l, 1), ev_str(obs_l, 2), ev_str(obs_l, 3));
    end
    d = first_diff(exp_w, obs_w); n_cmp++;
    if (d !== -1) begin n_fail++; $display("FAIL capture.writes: #%0d got %s, required %s", d, ev_str(obs_w, d), ev_str(exp_w, d)); end
    d = first_diff(exp_l, obs_l); n_cmp++;
    if (d !== -1) begin n_fail++; $display("FAIL capture.reads: #%0d got %s, required %s", d, ev_str(obs_l, d), ev_str(exp_l, d)); end
    n_cmp++;
    if (bf_bad !== 0) begin n_fail++; $display("FAIL capture.busy_full: %0d bad cycles (first %0d), required 0", bf_bad, bf_first); end
  endtask

  task automatic test_decim();
    int d;
    clear_logs();
    g_decim = 2;
    drive(0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 48; i++) drive(0, 0, 0, 0, 1, i);
    n_cmp++;
    if ({bus.o_mem_full, bus.o_mem_we, bus.o_mem_wdata} !== {1'b0, 1'b1, 32'd47}) begin
      n_fail++;
      $display("FAIL decim.last: full=%b we=%b data=%0d, required 0 1 47", bus.o_mem_full, bus.o_mem_we, bus.o_mem_wdata);
    end
    idle(1);
    n_cmp++;
    if (bus.o_mem_full !== 1'b1) begin
      n_fail++; $display("FAIL decim.full: full=%b, required 1", bus.o_mem_full);
    end
    n_cmp++;
    if (obs_w.size() !== 16 || obs_w[0].data !== 32'd2 || obs_w[1].data !== 32'd5) begin
      n_fail++;
      $display("FAIL decim.values: %0d writes, [0]=%s [1]=%s, required 16 writes 2,5,...", obs_w.size(), ev_str(obs_w, 0), ev_str(obs_w, 1));
    end
    d = first_diff(exp_w, obs_w); n_cmp++;
    if (d !== -1) begin n_fail++; $display("FAIL decim.writes: #%0d got %s, required %s", d, ev_str(obs_w, d), ev_str(exp_w, d)); end
    n_cmp++;
    if (bf_bad !== 0) begin n_fail++; $display("FAIL decim.busy_full: %0d bad cycles (first %0d), required 0", bf_bad, bf_first); end
  endtask

  task automatic test_restart();
    int d;
    clear_logs();
    g_decim = 0;
    drive(0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 32'h200 + i);
    drive(0, 1, 0, 0, 1, 32'h2FF);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, 32'h300 + i);
    n_cmp++;
    if (bus.o_mem_full !== 1'b0) begin n_fail++; $display("FAIL restart.early_full: full=%b, required 0", bus.o_mem_full); end
    idle(1);
    n_cmp++;
    if (obs_w.size() !== 24 || obs_w[8].addr !== 0 || obs_w[8].data !== 32'h300 || bus.o_mem_full !== 1'b1) begin
      n_fail++;
      $display("FAIL restart.addr0: %0d writes, [8]=%s, full=%b, required 24 writes, addr 0 data 300, full 1",
               obs_w.size(), ev_str(obs_w, 8), bus.o_mem_full);
    end
    d = first_diff(exp_w, obs_w); n_cmp++;
    if (d !== -1) begin n_fail++; $display("FAIL restart.writes: #%0d got %s, required %s", d, ev_str(obs_w, d), ev_str(exp_w, d)); end
    n_cmp++;
    if (bf_bad !== 0) begin n_fail++; $display("FAIL restart.busy_full: %0d bad cycles (first %0d), required 0", bf_bad, bf_first); end
  endtask

  task automatic test_collide();
    int d;
    clear_logs();
    drive(0, 0, 1, 2, 0, 32'h0);
    drive(0, 1, 1, 3, 0, 32'h0);
    n_cmp++;
    if ({bus.o_busy, bus.o_mem_full} !== 2'b10) begin
      n_fail++; $display("FAIL collide.state: busy/full=%b, required 10", {bus.o_busy, bus.o_mem_full});
    end
    idle(3);
    n_cmp++;
    if (obs_l.size() !== 1 || obs_l[0].data !== 32'h302) begin
      n_fail++; $display("FAIL collide.strobes: %0d strobes, [0]=%s, required 1 strobe data 302", obs_l.size(), ev_str(obs_l, 0));
    end
    drive(0, 0, 0, 0, 1, 32'h400);
    drive(0, 0, 0, 0, 1, 32'h401);
    n_cmp++;
    if (obs_w.size() !== 2 || obs_w[0].addr !== 0 || obs_w[0].data !== 32'h400) begin
      n_fail++; $display("FAIL collide.restart: %0d writes, [0]=%s, required addr 0 data 400", obs_w.size(), ev_str(obs_w, 0));
    end
    d = first_diff(exp_l, obs_l); n_cmp++;
    if (d !== -1) begin n_fail++; $display("FAIL collide.reads: #%0d got %s, required %s", d, ev_str(obs_l, d), ev_str(exp_l, d)); end
    n_cmp++;
    if (bf_bad !== 0) begin n_fail++; $display("FAIL collide.busy_full: %0d bad cycles (first %0d), required 0", bf_bad, bf_first); end
  endtask

  task automatic test_reset_mid();
    int d;
    clear_logs();
    drive(0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 32'h500 + i);
    drive(1, 0, 0, 0, 1, 32'h5FF);
    n_cmp++;
    if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_log_data, bus.o_log_vld,
         bus.o_mem_full, bus.o_busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid.outputs: we=%b addr=%h wdata=%h ldata=%h lvld=%b full=%b busy=%b, required all 0",
               bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_log_data, bus.o_log_vld,
               bus.o_mem_full, bus.o_busy);
    end
    idle(1);
    drive(0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, 32'h600 + i);
    idle(1);
    n_cmp++;
    if (obs_w.size() !== 26 || obs_w[10].addr !== 0 || obs_w[10].data !== 32'h600 || bus.o_mem_full !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid.recapture: %0d writes, [10]=%s, full=%b, required 26 writes, addr 0 data 600, full 1",
               obs_w.size(), ev_str(obs_w, 10), bus.o_mem_full);
    end
    d = first_diff(exp_w, obs_w); n_cmp++;
    if (d !== -1) begin n_fail++; $display("FAIL rstmid.writes: #%0d got %s, required %s", d, ev_str(obs_w, d), ev_str(exp_w, d)); end
    n_cmp++;
    if (bf_bad !== 0) begin n_fail++; $display("FAIL rstmid.busy_full: %0d bad cycles (first %0d), required 0", bf_bad, bf_first); end
  endtask

  task automatic test_random();
    int d;
    bit run;
    clear_logs();
    for (int c = 0; c < 1500; c++) begin
      run = (c == 0) || ($urandom_range(0, 149) == 0);
      if (run) g_decim = $urandom_range(0, 3);
      drive(($urandom_range(0, 599) == 0), run, ($urandom_range(0, 2) == 0),
            $urandom_range(0, DEPTH - 1), ($urandom_range(0, 9) < 7), $urandom);
    end
    idle(3);
    d = first_diff(exp_w, obs_w); n_cmp++;
    if (d !== -1) begin n_fail++; $display("FAIL random.writes: #%0d got %s, required %s", d, ev_str(obs_w, d), ev_str(exp_w, d)); end
    d = first_diff(exp_l, obs_l); n_cmp++;
    if (d !== -1) begin n_fail++; $display("FAIL random.reads: #%0d got %s, required %s", d, ev_str(obs_l, d), ev_str(exp_l, d)); end
    n_cmp++;
    if (bf_bad !== 0) begin n_fail++; $display("FAIL random.busy_full: %0d bad cycles (first %0d), required 0", bf_bad, bf_first); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; p = 0; g_decim = 0;
    m_phase = 0; m_v = 0; m_n = 0;
    i_rst = 1'b1;
    bus.i_run = 1'b0; bus.i_read = 1'b0; bus.i_read_addr = '0;
    bus.i_sample = '0; bus.i_sample_vld = 1'b0; bus.i_decim = '0;
    test_reset();
    test_capture_read();
    test_decim();
    test_restart();
    test_collide();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
